// File: rtl/dma_copy_engine_pkg.sv
// dma_copy_engine_pkg
// Shared definitions for the DMA copy engine slice: FSM state encoding,
// address width and the per-word address step.
// No ports. Imported by dma_copy_engine_if and dma_copy_engine.
package dma_copy_engine_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_BYTES = 4;

    // Byte increment applied to both pointers after every written word.
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if
// Memory-port bundle between the DMA engine (master) and the arbiter plus
// data memory (slave).
//   bus_req   master -> slave  request for the memory port
//   bus_gnt   slave  -> master grant from the arbiter
//   mem_addr  master -> slave  byte address
//   mem_wdata master -> slave  write data
//   mem_read  master -> slave  read strobe
//   mem_write master -> slave  write strobe
//   mem_rdata slave  -> master combinational read data
//
// Handshake: bus_req is a level request, held high for the whole transfer
// (REQ, READ, WRITE). The master only moves a word while bus_gnt is high,
// and only looks at bus_gnt in REQ and WRITE; once a word's READ has begun
// the arbiter must keep the grant until that word's WRITE has completed.
// Strobes are single-cycle: a read returns data in the same cycle, a write
// takes effect at the clock edge that closes the strobe cycle.
interface dma_copy_engine_if;
    import dma_copy_engine_pkg::*;

    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    modport master (
        output bus_req, mem_addr, mem_wdata, mem_read, mem_write,
        input  bus_gnt, mem_rdata
    );

    modport slave (
        input  bus_req, mem_addr, mem_wdata, mem_read, mem_write,
        output bus_gnt, mem_rdata
    );

endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
// Bus-master DMA engine: copies len 32-bit words from a source byte address
// to a destination byte address over the shared data-memory port, holding
// the CPU off through bus_req/bus_gnt. The copy is ascending with no overlap
// correction, and addresses wrap modulo 2^32.
//
// Optional feature macro: DMA_FILL_EN. When defined, fill_mode_i and
// fill_value_i exist and a fill writes fill_value_i to len words at one word
// per cycle without reads. When undefined the engine is copy-only.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start_i         launch request, sampled only in IDLE
//   src_addr_i      source byte address (word-aligned)
//   dst_addr_i      destination byte address (word-aligned)
//   len_i           number of words to move
//   fill_mode_i     (DMA_FILL_EN) 1 = fill instead of copy
//   fill_value_i    (DMA_FILL_EN) word written in fill mode
//   busy_o          high in REQ, READ, WRITE
//   done_o          one-cycle pulse in DONE
//   err_o           misalignment flag, sticky until next accepted start
//   state_o         current FSM state for observation
//   bus             memory port, master side
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [LEN_BITS-1:0] len_i,
`ifdef DMA_FILL_EN
    input  logic                fill_mode_i,
    input  logic [31:0]         fill_value_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output state_t              state_o,
    dma_copy_engine_if.master   bus
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic [31:0]         buf_q, buf_d;
    logic                err_q, err_d;

    // fill_start: fill requested at launch; fill_act: latched mode of the
    // transfer in progress. Both tie low in the copy-only build.
    logic fill_start;
    logic fill_act;
`ifdef DMA_FILL_EN
    logic fill_q, fill_d;
    assign fill_start = fill_mode_i;
    assign fill_act   = fill_q;
`else
    assign fill_start = 1'b0;
    assign fill_act   = 1'b0;
`endif

    // A fill never reads, so only the destination alignment matters there.
    logic misaligned;
    assign misaligned = (dst_addr_i[1:0] != 2'b00) ||
                        (!fill_start && (src_addr_i[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
`ifdef DMA_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        err_d   = err_q;
`ifdef DMA_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    rem_d = len_i;
                    err_d = 1'b0;
`ifdef DMA_FILL_EN
                    fill_d = fill_mode_i;
`endif
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_gnt) begin
                    state_d = fill_act ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                buf_d   = bus.mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                src_d = src_q + ADDR_STEP;
                dst_d = dst_q + ADDR_STEP;
                rem_d = rem_q - LEN_BITS'(1);
                if (rem_q == LEN_BITS'(1)) begin
                    state_d = ST_DONE;
                end else if (bus.bus_gnt) begin
                    state_d = fill_act ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs decode from the state alone, so reset silences the
    // memory port in the same instant it is asserted.
    always_comb begin
        busy_o        = 1'b0;
        done_o        = 1'b0;
        bus.bus_req   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_REQ: begin
                busy_o      = 1'b1;
                bus.bus_req = 1'b1;
            end
            ST_READ: begin
                busy_o       = 1'b1;
                bus.bus_req  = 1'b1;
                bus.mem_read = 1'b1;
                bus.mem_addr = src_q;
            end
            ST_WRITE: begin
                busy_o        = 1'b1;
                bus.bus_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = dst_q;
`ifdef DMA_FILL_EN
                bus.mem_wdata = fill_act ? fill_value_i : buf_q;
`else
                bus.mem_wdata = buf_q;
`endif
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign err_o   = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine
// Directed bench for dma_copy_engine with a 256-byte word memory and a
// grant model (bus_gnt = bus_req & gnt_allow). Cycle numbers follow the
// engine's timing: the edge that samples start is edge 0, cycle c is the
// interval after edge c-1. Outputs are sampled at the falling edge.
// Fill checks are built only with DMA_FILL_EN.
module tb_dma_copy_engine;
    import dma_copy_engine_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        fill_mode_i = 1'b0;
    logic [31:0] fill_value_i = '0;
    logic        busy_o, done_o, err_o;
    state_t      state_o;

    dma_copy_engine_if bus ();

    dma_copy_engine #(.LEN_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
`ifdef DMA_FILL_EN
        .fill_mode_i  (fill_mode_i),
        .fill_value_i (fill_value_i),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .state_o      (state_o),
        .bus          (bus)
    );

    // ---------------- memory + arbiter model ----------------
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_wa = '0;
    logic [31:0] pre_wd = '0;
    logic        gnt_allow = 1'b1;

    assign bus.bus_gnt   = bus.bus_req & gnt_allow;
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_wa] <= pre_wd;
        else if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1;
        pre_wa = 6'(idx);
        pre_wd = val;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Per-operation observations, filled in by run_op.
    int done_cycle, busy_first, busy_last, busy_cnt;
    int rd_cnt, wr_cnt, req_cnt, req_strobe, idle_nz;

    // Launch one operation (start asserted in the next cycle) and watch it
    // until done. Grant is withheld for cycles stall_lo..stall_hi; rep_c>0
    // re-pulses start (with a different source) in that cycle.
    task automatic run_op(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input logic fm, input logic [31:0] fv,
                          input int stall_lo, input int stall_hi, input int rep_c);
        @(negedge clk);
        src_addr_i   = s;
        dst_addr_i   = d;
        len_i        = n;
        fill_mode_i  = fm;
        fill_value_i = fv;
        start_i      = 1'b1;
        @(posedge clk);
        done_cycle = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
        rd_cnt = 0; wr_cnt = 0; req_cnt = 0; req_strobe = 0; idle_nz = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start_i = (c == rep_c);
            if (c == rep_c) src_addr_i = s + 32'h8;
            gnt_allow = !(c >= stall_lo && c <= stall_hi);
            if (busy_o) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (bus.mem_read) rd_cnt++;
            if (bus.mem_write) wr_cnt++;
            if (state_o == ST_REQ) begin
                req_cnt++;
                if (bus.mem_read || bus.mem_write) req_strobe++;
            end
            if (!bus.mem_read && !bus.mem_write &&
                (bus.mem_addr != 32'h0 || bus.mem_wdata != 32'h0)) idle_nz++;
            if (done_o) begin
                done_cycle = c;
                break;
            end
        end
        start_i   = 1'b0;
        gnt_allow = 1'b1;
        check("done_seen", 32'(done_cycle != 0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #12;
        check("rst_outs", {26'd0, busy_o, done_o, err_o, bus.bus_req, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) preload(i, 32'hA500_0000 | 32'(i));
        preload(0, 32'h11);
        preload(1, 32'h22);
        preload(2, 32'h33);
        preload(3, 32'h44);

        // Plain copy 0x00 -> 0x40, 3 words, grant held
        run_op(32'h00, 32'h40, 16'd3, 1'b0, 32'h0, 0, 0, 0);
        check("cp_done_cyc", 32'(done_cycle), 32'd8);
        check("cp_busy_first", 32'(busy_first), 32'd1);
        check("cp_busy_last", 32'(busy_last), 32'd7);
        check("cp_rd_wr", 32'(rd_cnt * 16 + wr_cnt), 32'(3 * 16 + 3));
        check("cp_idle_nz", 32'(idle_nz), 32'd0);
        check("cp_err", 32'(err_o), 32'd0);
        check("cp_w0", mem[16], 32'h11);
        check("cp_w1", mem[17], 32'h22);
        check("cp_w2", mem[18], 32'h33);
        check("cp_w3_untouched", mem[19], 32'hA500_0013);
        @(negedge clk);
        check("cp_back_idle", 32'(state_o), 32'(ST_IDLE));

        // Grant stall: grant low in cycles 3..5 -> REQ in 1,4,5,6
        run_op(32'h00, 32'h60, 16'd3, 1'b0, 32'h0, 3, 5, 0);
        check("st_done_cyc", 32'(done_cycle), 32'd11);
        check("st_req_cnt", 32'(req_cnt), 32'd4);
        check("st_req_strobe", 32'(req_strobe), 32'd0);
        check("st_w0", mem[24], 32'h11);
        check("st_w1", mem[25], 32'h22);
        check("st_w2", mem[26], 32'h33);

        // Misaligned source
        run_op(32'h02, 32'h40, 16'd3, 1'b0, 32'h0, 0, 0, 0);
        check("es_done_cyc", 32'(done_cycle), 32'd1);
        check("es_err", 32'(err_o), 32'd1);
        check("es_busy", 32'(busy_cnt), 32'd0);
        check("es_strobes", 32'(rd_cnt + wr_cnt), 32'd0);
        @(negedge clk);
        check("es_err_sticky", 32'(err_o), 32'd1);

        // Zero length clears the sticky error
        run_op(32'h00, 32'h40, 16'd0, 1'b0, 32'h0, 0, 0, 0);
        check("z_done_cyc", 32'(done_cycle), 32'd1);
        check("z_err", 32'(err_o), 32'd0);
        check("z_busy_strobes", 32'(busy_cnt + rd_cnt + wr_cnt), 32'd0);

        // Misaligned destination
        run_op(32'h00, 32'h41, 16'd2, 1'b0, 32'h0, 0, 0, 0);
        check("ed_done_cyc", 32'(done_cycle), 32'd1);
        check("ed_err", 32'(err_o), 32'd1);

        // start re-pulsed while busy is ignored; src stays 0x00
        run_op(32'h00, 32'hA0, 16'd2, 1'b0, 32'h0, 0, 0, 2);
        check("bz_done_cyc", 32'(done_cycle), 32'd6);
        check("bz_err", 32'(err_o), 32'd0);
        check("bz_w0", mem[40], 32'h11);
        check("bz_w1", mem[41], 32'h22);
        // start in the cycle right after DONE
        run_op(32'h08, 32'hB0, 16'd1, 1'b0, 32'h0, 0, 0, 0);
        check("bb_done_cyc", 32'(done_cycle), 32'd4);
        check("bb_w0", mem[44], 32'h33);

`ifdef DMA_FILL_EN
        // Fill 0x80..0x8C; source misalignment is irrelevant in fill mode
        run_op(32'h03, 32'h80, 16'd4, 1'b1, 32'hDEADBEEF, 0, 0, 0);
        check("fl_done_cyc", 32'(done_cycle), 32'd6);
        check("fl_err", 32'(err_o), 32'd0);
        check("fl_rd", 32'(rd_cnt), 32'd0);
        check("fl_wr", 32'(wr_cnt), 32'd4);
        for (int i = 32; i < 36; i++) check("fl_word", mem[i], 32'hDEADBEEF);
        check("fl_after", mem[36], 32'hA500_0024);
`endif

        // Reset mid-transfer: 4-word copy to 0xC0. Word 1's write lands at
        // edge 5 (end of its WRITE cycle); reset rises just after that edge.
        @(negedge clk);
        src_addr_i = 32'h00;
        dst_addr_i = 32'hC0;
        len_i      = 16'd4;
        fill_mode_i = 1'b0;
        start_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rm_outs", {26'd0, busy_o, done_o, err_o, bus.bus_req, bus.mem_read, bus.mem_write}, 32'd0);
        check("rm_addr", bus.mem_addr, 32'd0);
        check("rm_state", 32'(state_o), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        done_cycle = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_o || busy_o) done_cycle++;
        end
        check("rm_no_done", 32'(done_cycle), 32'd0);
        check("rm_w0", mem[48], 32'h11);
        check("rm_w1", mem[49], 32'h22);
        check("rm_w2", mem[50], 32'hA500_0032);
        check("rm_w3", mem[51], 32'hA500_0033);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
